// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit, 33-cycle fixed latency, single outstanding op.
module mul_div_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag, hi, lo;

    logic            in_sa, in_sb, in_a_neg, in_b_neg;
    logic [XLEN-1:0] in_a_mag, in_b_mag;
    logic [XLEN:0]   mul_sum, div_sh;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] quo_s, rem_s, a_orig, mul_res, div_res, fin_res;
    logic            b_zero, ovf;

    // MUL low word is sign-agnostic, so it shares the signed path with MULH
    always_comb begin
        in_sa    = funct3[2] ? ~funct3[0] : ~(funct3[1] & funct3[0]);
        in_sb    = funct3[2] ? ~funct3[0] : ~funct3[1];
        in_a_neg = in_sa & op_a[XLEN-1];
        in_b_neg = in_sb & op_b[XLEN-1];
        in_a_mag = in_a_neg ? -op_a : op_a;
        in_b_mag = in_b_neg ? -op_b : op_b;
    end

    // hi:lo is the product accumulator for multiply, remainder:quotient for divide
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : '0);
        div_sh   = {hi, lo[XLEN-1]};
        div_ge   = div_sh >= {1'b0, b_mag};
        div_diff = div_sh[XLEN-1:0] - b_mag;
    end

    always_comb begin
        prod_s  = (a_neg ^ b_neg) ? -{hi, lo} : {hi, lo};
        quo_s   = (a_neg ^ b_neg) ? -lo : lo;
        rem_s   = a_neg ? -hi : hi;
        a_orig  = a_neg ? -a_mag : a_mag;
        b_zero  = b_mag == '0;
        ovf     = ~f3[0] & a_neg & b_neg & (a_mag == MIN_NEG) & (b_mag == XLEN'(1));
        mul_res = (f3[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        div_res = f3[1] ? (b_zero ? a_orig : ovf ? '0 : rem_s)
                        : (b_zero ? '1 : ovf ? MIN_NEG : quo_s);
        fin_res = f3[2] ? div_res : mul_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
            cnt    <= '0;
            f3     <= '0;
            rd     <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && kill) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (state == IDLE) begin
                if (start && !kill) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    cnt   <= '0;
                    f3    <= funct3;
                    rd    <= rd_in;
                    a_neg <= in_a_neg;
                    b_neg <= in_b_neg;
                    a_mag <= in_a_mag;
                    b_mag <= in_b_mag;
                    hi    <= '0;
                    lo    <= funct3[2] ? in_a_mag : in_b_mag;
                end
            end else if (state == RUN) begin
                if (f3[2]) begin
                    hi <= div_ge ? div_diff : div_sh[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], div_ge};
                end else begin
                    hi <= mul_sum[XLEN:1];
                    lo <= {mul_sum[0], lo[XLEN-1:1]};
                end
                cnt <= cnt + 1'b1;
                if (cnt == LAST) state <= FINISH;
            end else begin
                result <= fin_res;
                rd_out <= rd;
                done   <= 1'b1;
                busy   <= 1'b0;
                state  <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed checks of mul_div_unit latency, handshake, kill, reset and arithmetic.
module tb_mul_div_unit;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, kill = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    int tests = 0, fails = 0;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t mv [0:5] = '{
        '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000},
        '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
        '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
        '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
        '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF},
        '{3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001}
    };

    vec_t dv [0:11] = '{
        '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},
        '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},
        '{3'b101, 32'd100,      32'h00000000, 32'hFFFFFFFF},
        '{3'b111, 32'd100,      32'h00000000, 32'h00000064},
        '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
        '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
        '{3'b100, 32'd7,        32'h00000000, 32'hFFFFFFFF},
        '{3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9},
        '{3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC},
        '{3'b111, 32'hFFFFFFF9, 32'h00000002, 32'h00000001},
        '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD},
        '{3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001}
    };

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        tick;
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        funct3 = 3'($urandom); rd_in = 5'($urandom);
        lat = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            tick;
            if (done) lat = k;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        tests += 4;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 0", result); end
        if (rd_out !== 5'd0) begin fails++; $display("FAIL reset_rd: got %0d want 0", rd_out); end
    endtask

    task automatic test_mul_timing;
        funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFFFFFD; rd_in = 5'd5; start = 1'b1;
        tick;
        start = 1'b0; op_a = 32'h12345678; op_b = 32'h9ABCDEF0; rd_in = 5'd17;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) tick;
            tests++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL mul_busy_edge%0d: busy=%b done=%b want busy=1 done=0", k, busy, done);
            end
        end
        tick;
        tests += 4;
        if (done !== 1'b1) begin fails++; $display("FAIL mul_done33: got %b want 1", done); end
        if (busy !== 1'b0) begin fails++; $display("FAIL mul_busy33: got %b want 0", busy); end
        if (result !== 32'hFFFFFFEB) begin fails++; $display("FAIL mul_result: got %h want ffffffeb", result); end
        if (rd_out !== 5'd5) begin fails++; $display("FAIL mul_rd: got %0d want 5", rd_out); end
        tick;
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL mul_done34: got %b want 0", done); end
    endtask

    task automatic test_mul_high;
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(mv[i].f, mv[i].a, mv[i].b, 5'(i + 1), lat);
            tests += 3;
            if (lat != 33) begin fails++; $display("FAIL mulv%0d_latency: got %0d want 33", i, lat); end
            if (result !== mv[i].e) begin fails++; $display("FAIL mulv%0d_result: got %h want %h", i, result, mv[i].e); end
            if (rd_out !== 5'(i + 1)) begin fails++; $display("FAIL mulv%0d_rd: got %0d want %0d", i, rd_out, i + 1); end
            tick;
        end
    endtask

    task automatic test_div;
        int lat;
        for (int i = 0; i < 12; i++) begin
            issue(dv[i].f, dv[i].a, dv[i].b, 5'(i + 10), lat);
            tests += 2;
            if (lat != 33) begin fails++; $display("FAIL divv%0d_latency: got %0d want 33", i, lat); end
            if (result !== dv[i].e) begin fails++; $display("FAIL divv%0d_result: got %h want %h", i, result, dv[i].e); end
        end
    endtask

    task automatic test_back_to_back;
        int second;
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd1; start = 1'b1;
        tick;
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd2;
        for (int k = 1; k <= 32; k++) begin
            tick;
            tests++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL b2b_first_edge%0d: busy=%b done=%b want busy=1 done=0", k, busy, done);
            end
        end
        tick;
        tests += 3;
        if (done !== 1'b1) begin fails++; $display("FAIL b2b_done33: got %b want 1", done); end
        if (result !== 32'd12) begin fails++; $display("FAIL b2b_result1: got %h want 0000000c", result); end
        if (rd_out !== 5'd1) begin fails++; $display("FAIL b2b_rd1: got %0d want 1", rd_out); end
        tick;
        start = 1'b0;
        tests += 2;
        if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept34_busy: got %b want 1", busy); end
        if (done !== 1'b0) begin fails++; $display("FAIL b2b_accept34_done: got %b want 0", done); end
        second = 0;
        for (int k = 35; k <= 100 && second == 0; k++) begin
            tick;
            if (done) second = k;
        end
        tests += 3;
        if (second != 67) begin fails++; $display("FAIL b2b_done_edge: got %0d want 67", second); end
        if (result !== 32'd14) begin fails++; $display("FAIL b2b_result2: got %h want 0000000e", result); end
        if (rd_out !== 5'd2) begin fails++; $display("FAIL b2b_rd2: got %0d want 2", rd_out); end
        tick;
    endtask

    task automatic test_kill;
        int lat;
        funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd3; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 9; k++) tick;
        kill = 1'b1;
        tick;
        kill = 1'b0;
        tests += 4;
        if (busy !== 1'b0) begin fails++; $display("FAIL kill_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin fails++; $display("FAIL kill_done: got %b want 0", done); end
        if (result !== 32'd14) begin fails++; $display("FAIL kill_result_kept: got %h want 0000000e", result); end
        if (rd_out !== 5'd2) begin fails++; $display("FAIL kill_rd_kept: got %0d want 2", rd_out); end
        tick;
        issue(3'b000, 32'd6, 32'd7, 5'd4, lat);
        tests += 3;
        if (lat != 33) begin fails++; $display("FAIL kill_restart_edge: got %0d want 45", lat + 12); end
        if (result !== 32'd42) begin fails++; $display("FAIL kill_restart_result: got %h want 0000002a", result); end
        if (rd_out !== 5'd4) begin fails++; $display("FAIL kill_restart_rd: got %0d want 4", rd_out); end
        tick;
        funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd6; start = 1'b1; kill = 1'b1;
        tick;
        start = 1'b0; kill = 1'b0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL kill_start_idle_busy: got %b want 0", busy); end
        for (int k = 0; k < 40; k++) begin
            tick;
            tests++;
            if (done !== 1'b0) begin fails++; $display("FAIL kill_start_idle_done%0d: got %b want 0", k, done); end
        end
    endtask

    task automatic test_reset_mid;
        funct3 = 3'b011; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; rd_in = 5'd9; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 19; k++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tests += 4;
        if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin fails++; $display("FAIL rstmid_done: got %b want 0", done); end
        if (result !== 32'h0) begin fails++; $display("FAIL rstmid_result: got %h want 0", result); end
        if (rd_out !== 5'd0) begin fails++; $display("FAIL rstmid_rd: got %0d want 0", rd_out); end
        for (int k = 0; k < 40; k++) begin
            tick;
            tests++;
            if (done !== 1'b0) begin fails++; $display("FAIL rstmid_no_done%0d: got %b want 0", k, done); end
        end
    endtask

    initial begin
        test_reset;
        test_mul_timing;
        test_mul_high;
        test_div;
        test_back_to_back;
        test_kill;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide execution unit for the multi-cycle core.
- Consumes the two registered source operands produced by the register file read stage.
- Returns a 32-bit result and destination index to the writeback path, which drives register-file write data and write enable.
- Fixed-latency, single-outstanding-operation design with start/busy/done handshake.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- ITER, 32, iteration count; must equal XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- kill  in  1  abort in-flight operation (pipeline flush)
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  32  rs1 value
- op_b  in  32  rs2 value
- rd_in  in  5  destination register index
- busy  out  1  operation in flight
- done  out  1  one-cycle result-valid pulse
- result  out  32  result; held until next done
- rd_out  out  5  destination index captured at accept

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- Reset values: busy=0, done=0, result=0, rd_out=0, state=IDLE.
- Reset mid-operation discards all work; no done pulse is produced.
- States and transitions:
  - IDLE: on start=1 at edge N, latch funct3, rd_in, and operand magnitudes plus sign flags; clear the counter; busy=1; go to RUN. op_a/op_b are don't-care after edge N.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. The counter increments; when it reaches ITER-1, go to FINISH. Edges N+1..N+32.
  - FINISH: at edge N+33, apply sign correction and special-case override, register result and rd_out, set done=1 and busy=0, go to IDLE.
- Handshake timing:
  - done is high only in cycle N+33..N+34.
  - busy is high from edge N to edge N+33.
  - start sampled at edge N+34 (while done is high) is legal and accepted.
  - start while busy=1 is ignored and has no side effects.
- Kill: kill=1 in RUN or FINISH forces IDLE at the next edge with busy=0 and no done. result and rd_out keep their previous values. kill has priority over FINISH completion. kill together with start in IDLE means no accept.
- Multiply rules:
  - Signedness per funct3: MULH is signed×signed, MULHSU is signed×unsigned, MULHU is unsigned×unsigned.
  - Compute the unsigned 64-bit magnitude product, then negate when operand signs differ, for signed variants only.
  - MUL returns bits [31:0]; the others return bits [63:32].
- Divide rules:
  - DIV/REM operate on magnitudes. The quotient is negated when signs differ. The remainder takes the dividend's sign (truncating division).
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
  - Overflow, DIV with 0x80000000 / 0xFFFFFFFF: return 0x80000000; REM returns 0.
  - Special cases still take the full 33-cycle latency, so latency is constant for all funct3.
- rd_out=0 is allowed; the result is still computed and writeback suppresses it.
- done and busy are never high in the same cycle.

Test Plan:
- MUL, op_a=7, op_b=0xFFFFFFFD, start at edge 0 -> busy 1 on edges 0..32; done high exactly one cycle after edge 33; result=0xFFFFFFEB; rd_out equals captured rd_in=5.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF. MUL low word for the same operands -> 0x00000001.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU 100/0 -> 0xFFFFFFFF. REMU 100/0 -> 0x00000064. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM -> 0. All complete at edge 33.
- Back-to-back: second start held high through the first operation -> ignored while busy, accepted at edge 34 (done cycle), second done after edge 67. Changing op_a/op_b after edge 0 does not alter the first result.
- kill at edge 10 of a DIV -> busy 0 after edge 10, no done ever, result retains previous value; new start at edge 12 completes normally after edge 45.
- rst=1 at edge 20 mid-MULHU -> busy=0, done=0, result=0, rd_out=0 after that edge; no done appears in the following 40 cycles.
